ssd_to_binary: RTL and testbench

Sequential decoder that reads back a bank of seven-segment digit patterns and reconstructs the binary value they display, the inverse of the binary-to-display path. Sits on the self-check/readback side of the reaction-timer display: it samples the four segment vectors driven to the display, decodes each pattern to a decimal digit, and accumulates MSB-first into a binary result. A valid/ready handshake is used on both sides. Per-digit illegal-pattern flags are reported.

---
 rtl/ssd_to_binary_pkg.sv | 27 ++
 rtl/ssd_to_binary_if.sv | 28 ++
 rtl/ssd_to_binary_decode.sv | 33 +++
 rtl/ssd_to_binary.sv | 89 ++++++++
 tb/tb_ssd_to_binary.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ssd_to_binary_pkg.sv
// Shared constants, FSM state type and width helper for the seven-segment readback decoder.
// Segment patterns are logical (lit = 1), listed g..a from bit 6 down to bit 0.
package ssd_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    function automatic int unsigned digits_width(input int unsigned n);
        return $clog2(10 ** n);
    endfunction

endpackage

// File: rtl/ssd_to_binary_if.sv
// Valid/ready bus between a segment-pattern source/result consumer and the decoder.
interface ssd_to_binary_if
    import ssd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W = digits_width(DIGITS);

    logic                        in_valid;
    logic                        in_ready;
    logic [DIGITS-1:0][6:0]      seg_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [W-1:0]                binary_out;
    logic [DIGITS-1:0]           digit_err;
    logic                        out_error;

    modport master (
        output in_valid, seg_in, out_ready,
        input  in_ready, out_valid, binary_out, digit_err, out_error
    );

    modport slave (
        input  in_valid, seg_in, out_ready,
        output in_ready, out_valid, binary_out, digit_err, out_error
    );

endinterface

// File: rtl/ssd_to_binary_decode.sv
// Combinational seven-segment pattern to decimal digit decoder with legality flag.
module seven_segment_decode
    import ssd_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       valid
);
    logic [6:0] logical;

    always_comb begin
        logical = ACTIVE_LOW ? ~seg : seg;
        digit   = '0;
        valid   = 1'b1;
        case (logical)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            SEG_BLANK: digit = 4'd0;
            default:   valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_to_binary.sv
// Reads back a captured bank of seven-segment patterns and accumulates them
// MSB-first into a binary value, one digit per clock.
module ssd_to_binary
    import ssd_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    ssd_to_binary_if.slave bus
);
    localparam int unsigned W  = digits_width(DIGITS);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t                 state;
    logic [DIGITS-1:0][6:0] seg_q;
    logic [IW-1:0]          idx;
    logic [W-1:0]           acc;
    logic [DIGITS-1:0]      err;
    logic                   in_ready_q;
    logic                   out_valid_q;

    logic [3:0]             dig;
    logic                   dig_ok;
    logic [W-1:0]           mac;

    seven_segment_decode #(
        .ACTIVE_LOW(ACTIVE_LOW)
    ) u_decode (
        .seg   (seg_q[idx]),
        .digit (dig),
        .valid (dig_ok)
    );

    // acc*10 as shift-add; the result never exceeds 10**DIGITS-1 so W bits suffice.
    always_comb begin
        mac = (acc << 3) + (acc << 1) + W'(dig);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            seg_q       <= '0;
            idx         <= '0;
            acc         <= '0;
            err         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        seg_q      <= bus.seg_in;
                        acc        <= '0;
                        err        <= '0;
                        idx        <= IW'(DIGITS - 1);
                        in_ready_q <= 1'b0;
                        state      <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc      <= mac;
                    err[idx] <= ~dig_ok;
                    idx      <= idx - 1'b1;
                    if (idx == '0) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.binary_out = acc;
    assign bus.digit_err  = err;
    assign bus.out_error  = |err;

endmodule

// File: tb/tb_ssd_to_binary.sv
// Directed self-checking bench for ssd_to_binary (DIGITS=4, active-low segments).
module tb_ssd_to_binary;

    // Active-low patterns, g..a.
    localparam logic [6:0] AL_0   = 7'b1000000;
    localparam logic [6:0] AL_1   = 7'b1111001;
    localparam logic [6:0] AL_2   = 7'b0100100;
    localparam logic [6:0] AL_4   = 7'b0011001;
    localparam logic [6:0] AL_6   = 7'b0000010;
    localparam logic [6:0] AL_7   = 7'b1111000;
    localparam logic [6:0] AL_9   = 7'b0010000;
    localparam logic [6:0] AL_BLK = 7'b1111111;
    localparam logic [6:0] AL_BAD = 7'b1110111;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    ssd_to_binary_if #(.DIGITS(4)) bus ();

    ssd_to_binary #(
        .DIGITS     (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " in_ready"},  32'(bus.in_ready),   32'd1);
        check({tag, " out_valid"}, 32'(bus.out_valid),  32'd0);
    endtask

    // Accept one set, wait (bounded) for the result, check it; leaves the DUT in DONE.
    task automatic run_conv(input string tag, input logic [27:0] segs,
                            input logic [31:0] exp_val, input logic [3:0] exp_err);
        bus.seg_in   = segs;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) step();
        check({tag, " out_valid"},  32'(bus.out_valid),  32'd1);
        check({tag, " binary_out"}, 32'(bus.binary_out), exp_val);
        check({tag, " digit_err"},  32'(bus.digit_err),  32'(exp_err));
        check({tag, " out_error"},  32'(bus.out_error),  32'(|exp_err));
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_idle({tag, " release"});
    endtask

    initial begin
        logic [27:0] segs_a;
        logic [27:0] segs_b;
        int          n;
        int          t_first;
        int          t_second;
        logic        accepting;
        n_cmp        = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.seg_in   = '1;
        step();
        step();
        reset = 1'b0;
        check_idle("reset");
        check("reset binary_out", 32'(bus.binary_out), 32'd0);
        check("reset digit_err",  32'(bus.digit_err),  32'd0);
        check("reset out_error",  32'(bus.out_error),  32'd0);

        // 7601 with exact latency: out_valid rises after the 4th edge following acceptance.
        bus.seg_in   = {AL_7, AL_6, AL_0, AL_1};
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        check("lat in_ready low", 32'(bus.in_ready), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("lat out_valid edge%0d", i), 32'(bus.out_valid), 32'd0);
        end
        step();
        check("lat out_valid edge4", 32'(bus.out_valid),  32'd1);
        check("7601 binary_out",     32'(bus.binary_out), 32'd7601);
        check("7601 out_error",      32'(bus.out_error),  32'd0);
        release_out("7601");

        run_conv("9999",  {AL_9, AL_9, AL_9, AL_9},         32'd9999, 4'b0000);
        release_out("9999");
        run_conv("blank", {AL_BLK, AL_BLK, AL_BLK, AL_BLK}, 32'd0,    4'b0000);
        release_out("blank");
        run_conv("illegal", {AL_1, AL_BAD, AL_1, AL_1},     32'd1011, 4'b0100);

        // Hold DONE with out_ready low while the source toggles seg_in and in_valid.
        for (int i = 0; i < 10; i++) begin
            bus.seg_in   = ~bus.seg_in;
            bus.in_valid = i[0];
            step();
            check($sformatf("hold%0d out_valid", i),  32'(bus.out_valid),  32'd1);
            check($sformatf("hold%0d binary_out", i), 32'(bus.binary_out), 32'd1011);
            check($sformatf("hold%0d in_ready", i),   32'(bus.in_ready),   32'd0);
        end
        bus.in_valid = 1'b0;
        release_out("hold");

        // Reset sampled at the end of the second ACCUM cycle, with an illegal MSB already flagged.
        bus.seg_in   = {AL_BAD, AL_7, AL_7, AL_7};
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        check("midreset err seen", 32'(bus.digit_err), 32'b1000);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("midreset");
        check("midreset binary_out", 32'(bus.binary_out), 32'd0);
        check("midreset digit_err",  32'(bus.digit_err),  32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("midreset quiet%0d", i), 32'(bus.out_valid), 32'd0);
        end
        run_conv("0042", {AL_0, AL_0, AL_4, AL_2}, 32'd42, 4'b0000);
        release_out("0042");

        // reset together with in_valid: nothing captured.
        bus.seg_in   = {AL_9, AL_9, AL_9, AL_9};
        bus.in_valid = 1'b1;
        reset        = 1'b1;
        step();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        check_idle("reset+valid");
        step();
        check_idle("reset+valid after");

        // Back-to-back with out_ready tied high: second acceptance 6 cycles after the first.
        segs_a        = {AL_1, AL_2, AL_0, AL_4};
        segs_b        = {AL_6, AL_0, AL_9, AL_7};
        bus.out_ready = 1'b1;
        bus.seg_in    = segs_a;
        bus.in_valid  = 1'b1;
        t_first       = -1;
        t_second      = -1;
        n             = 0;
        while (n < 40 && t_second < 0) begin
            accepting = bus.in_ready && bus.in_valid;
            step();
            n++;
            if (bus.out_valid)
                check("b2b first result", 32'(bus.binary_out), 32'd1204);
            if (accepting) begin
                if (t_first < 0) begin
                    t_first    = n;
                    bus.seg_in = segs_b;
                end else begin
                    t_second     = n;
                    bus.in_valid = 1'b0;
                end
            end
        end
        check("b2b second accepted", 32'(t_second >= 0), 32'd1);
        check("b2b interval", 32'(t_second - t_first), 32'd6);
        for (int i = 0; i < 20 && !bus.out_valid; i++) step();
        check("b2b second result", 32'(bus.binary_out), 32'd6097);
        bus.out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
